// File: rtl/turf_header_pkg.sv
// Shared definitions for the TURF event-header stream (thdr).
// Used by the header generator and by turf_header_parser.
//  - qword0 signature (format tag + header word count)
//  - bit positions of the summarised fields
//  - thdr_summary_t: one-per-event summary record
package turf_header_pkg;

  localparam int          HEADER_QWORDS     = 16;
  localparam logic [15:0] THDR_FORMAT       = 16'h4531;  // "E1"
  localparam logic [15:0] THDR_HEADER_WORDS = 16'd63;
  localparam logic [15:0] THDR_SURF_WORDS   = 16'd64;
  localparam logic [31:0] THDR_QW0_MAGIC    = {THDR_FORMAT, THDR_HEADER_WORDS};

  // Field bit positions (LSB of each field within its qword)
  localparam int QW0_NUMBER_LSB    = 32;
  localparam int QW1_SEC_LSB       = 0;
  localparam int QW1_TIME_LSB      = 32;
  localparam int QW2_LAST_PPS_LSB  = 0;
  localparam int QW2_LLAST_PPS_LSB = 32;
  localparam int QW15_RUNCFG_LSB   = 32;
  localparam int QW15_TIO_LSB      = 44;
  localparam int QW15_SURF_LSB     = 48;

  typedef struct packed {
    logic [31:0] number;
    logic [31:0] sec;
    logic [31:0] tstamp;
    logic [31:0] last_pps;
    logic [31:0] llast_pps;
    logic [3:0]  tio_mask;
    logic [11:0] runcfg;
    logic [15:0] surf_words;
  } thdr_summary_t;

  // Only the low half of qword0 carries the signature.
  function automatic logic qw0_good(input logic [31:0] qw_lo);
    return qw_lo == THDR_QW0_MAGIC;
  endfunction

endpackage

// File: rtl/turf_header_parser_if.sv
// 64-bit AXI-stream style link used for the header stream.
//  master: drives tdata/tvalid/tlast, samples tready
//  slave : samples tdata/tvalid, drives tready (the FIFO side carries no tlast)
interface turf_header_parser_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/turf_hdr_axis_slice.sv
// 1-deep forward register slice, 64-bit data + tlast.
//  in_*  : upstream side (in_ready = slot free or draining this clock)
//  out_* : registered downstream side
// Full throughput: a held word can be replaced in the same clock it drains.
module turf_hdr_axis_slice (
  input  logic        memclk,
  input  logic        memresetn,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
      end
    end
  end
endmodule

// File: rtl/turf_header_parser.sv
// Consumer end of the TURF event-header stream (memclk domain).
// Validates qword0, checks event-number continuity, forwards all 16 qwords
// with tlast on qword15 and presents one summary record per event.
// Ports:
//  memclk, memresetn          clock, async active-low reset
//  s_thdr (slave)             header qwords from the FIFO
//  m_hdr  (master)            forwarded qwords, tlast on qword15
//  ev_valid/ev_ready, ev_*    per-event summary record
//  resync_i                   next good qword0 starts a new sequence
//  err_format_o / _cnt        bad qword0 dropped (pulse / saturating count)
//  err_seq_o / _cnt           event-number discontinuity (pulse / saturating count)
module turf_header_parser
  import turf_header_pkg::*;
#(
  parameter int ERRCNT_BITS = 16
) (
  input  logic                   memclk,
  input  logic                   memresetn,
  turf_header_parser_if.slave    s_thdr,
  turf_header_parser_if.master   m_hdr,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [31:0]            ev_number,
  output logic [31:0]            ev_sec,
  output logic [31:0]            ev_time,
  output logic [31:0]            ev_last_pps,
  output logic [31:0]            ev_llast_pps,
  output logic [3:0]             ev_tio_mask,
  output logic [11:0]            ev_runcfg,
  output logic [15:0]            ev_surf_words,
  input  logic                   resync_i,
  output logic                   err_format_o,
  output logic                   err_seq_o,
  output logic [ERRCNT_BITS-1:0] err_format_cnt,
  output logic [ERRCNT_BITS-1:0] err_seq_cnt
);
  localparam int               IDX_W    = $clog2(HEADER_QWORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HEADER_QWORDS - 1);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_BODY    = 2'd1;
  localparam logic [1:0] ST_SUMMARY = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             run_q;        // holds tready low while in reset
  logic             first_event;
  logic [31:0]      prev_num;
  thdr_summary_t    sum_q;

  logic        qw0_ok, slot_free, acc, take_qw0, take_body, drop, fwd, fwd_last, seq_bad;
  logic [31:0] qw_num;

  assign qw0_ok = qw0_good(s_thdr.tdata[31:0]);
  assign qw_num = s_thdr.tdata[QW0_NUMBER_LSB +: 32];

  // Bad qword0s are swallowed without waiting on the downstream slot.
  always_comb begin
    s_thdr.tready = 1'b0;
    if (run_q) begin
      case (state)
        ST_HUNT: s_thdr.tready = qw0_ok ? slot_free : 1'b1;
        ST_BODY: s_thdr.tready = slot_free;
        default: s_thdr.tready = 1'b0;
      endcase
    end
  end

  assign acc       = s_thdr.tvalid && s_thdr.tready;
  assign take_qw0  = acc && (state == ST_HUNT) && qw0_ok;
  assign drop      = acc && (state == ST_HUNT) && !qw0_ok;
  assign take_body = acc && (state == ST_BODY);
  assign fwd       = take_qw0 || take_body;
  assign fwd_last  = (state == ST_BODY) && (idx == IDX_LAST);
  // resync_i coinciding with qword0 makes that header the first of a sequence.
  assign seq_bad   = take_qw0 && !(first_event || resync_i) && (qw_num != prev_num + 32'd1);

  turf_hdr_axis_slice u_slice (
    .memclk    (memclk),
    .memresetn (memresetn),
    .in_data   (s_thdr.tdata),
    .in_last   (fwd_last),
    .in_valid  (fwd),
    .in_ready  (slot_free),
    .out_data  (m_hdr.tdata),
    .out_last  (m_hdr.tlast),
    .out_valid (m_hdr.tvalid),
    .out_ready (m_hdr.tready)
  );

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      state <= ST_HUNT;
      idx   <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_HUNT: if (take_qw0) begin
          state <= ST_BODY;
          idx   <= IDX_W'(1);
        end
        ST_BODY: if (take_body) begin
          if (idx == IDX_LAST) state <= ST_SUMMARY;
          idx <= idx + 1'b1;
        end
        ST_SUMMARY: if (ev_ready) state <= ST_HUNT;
        default: state <= ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      first_event    <= 1'b1;
      prev_num       <= '0;
      err_format_o   <= 1'b0;
      err_seq_o      <= 1'b0;
      err_format_cnt <= '0;
      err_seq_cnt    <= '0;
    end else begin
      err_format_o <= drop;
      err_seq_o    <= seq_bad;
      if (drop && !(&err_format_cnt)) err_format_cnt <= err_format_cnt + 1'b1;
      if (seq_bad && !(&err_seq_cnt)) err_seq_cnt <= err_seq_cnt + 1'b1;
      if (take_qw0) begin
        prev_num    <= qw_num;
        first_event <= 1'b0;
      end else if (resync_i) begin
        first_event <= 1'b1;
      end
    end
  end

  // Summary fields; only qwords 1, 2 and 15 are interpreted past qword0.
  always_ff @(posedge memclk or negedge memresetn) begin
    if (!memresetn) begin
      sum_q <= '0;
    end else begin
      if (take_qw0) sum_q.number <= qw_num;
      if (take_body) begin
        if (idx == IDX_W'(1)) begin
          sum_q.sec    <= s_thdr.tdata[QW1_SEC_LSB +: 32];
          sum_q.tstamp <= s_thdr.tdata[QW1_TIME_LSB +: 32];
        end
        if (idx == IDX_W'(2)) begin
          sum_q.last_pps  <= s_thdr.tdata[QW2_LAST_PPS_LSB +: 32];
          sum_q.llast_pps <= s_thdr.tdata[QW2_LLAST_PPS_LSB +: 32];
        end
        if (idx == IDX_LAST) begin
          sum_q.runcfg     <= s_thdr.tdata[QW15_RUNCFG_LSB +: 12];
          sum_q.tio_mask   <= s_thdr.tdata[QW15_TIO_LSB +: 4];
          sum_q.surf_words <= s_thdr.tdata[QW15_SURF_LSB +: 16];
        end
      end
    end
  end

  assign ev_valid      = (state == ST_SUMMARY);
  assign ev_number     = sum_q.number;
  assign ev_sec        = sum_q.sec;
  assign ev_time       = sum_q.tstamp;
  assign ev_last_pps   = sum_q.last_pps;
  assign ev_llast_pps  = sum_q.llast_pps;
  assign ev_tio_mask   = sum_q.tio_mask;
  assign ev_runcfg     = sum_q.runcfg;
  assign ev_surf_words = sum_q.surf_words;
endmodule

// File: tb/tb_turf_header_parser.sv
// Bench for turf_header_parser: directed header scenarios plus a randomized
// run, checked every cycle against a header-level model kept below.
module tb_turf_header_parser;
  logic memclk = 1'b0;
  logic memresetn = 1'b1;
  always #5 memclk = ~memclk;

  turf_header_parser_if s_if ();
  turf_header_parser_if m_if ();

  logic        ev_valid, ev_ready, resync_i, err_format_o, err_seq_o;
  logic [31:0] ev_number, ev_sec, ev_time, ev_last_pps, ev_llast_pps;
  logic [3:0]  ev_tio_mask;
  logic [11:0] ev_runcfg;
  logic [15:0] ev_surf_words, err_format_cnt, err_seq_cnt;

  turf_header_parser #(.ERRCNT_BITS(16)) dut (
    .memclk(memclk), .memresetn(memresetn), .s_thdr(s_if), .m_hdr(m_if),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_number(ev_number), .ev_sec(ev_sec),
    .ev_time(ev_time), .ev_last_pps(ev_last_pps), .ev_llast_pps(ev_llast_pps),
    .ev_tio_mask(ev_tio_mask), .ev_runcfg(ev_runcfg), .ev_surf_words(ev_surf_words),
    .resync_i(resync_i), .err_format_o(err_format_o), .err_seq_o(err_seq_o),
    .err_format_cnt(err_format_cnt), .err_seq_cnt(err_seq_cnt)
  );

  localparam logic [31:0] MAGIC = 32'h4531_003F;  // {"E1", 16'd63}

  typedef struct { logic [63:0] d; bit r; } src_t;
  typedef struct { logic [63:0] d; bit l; } fw_t;

  int tests = 0, fails = 0;
  src_t src_q[$];
  src_t cur;
  fw_t  fwd_q[$];
  logic [63:0] hdr[16];
  logic [63:0] pend_hdr[16];
  int pos = 0;
  bit pend = 0, first = 1, exp_fmt = 0, exp_seq = 0, acc_prev = 0, resync_req = 0;
  logic [31:0] prev = '0;
  int m_fmt_cnt = 0, m_seq_cnt = 0;
  bit rnd_mready = 0, rnd_evready = 0, rnd_gap = 0;
  int ev_hold = 0, since_rst = 0, cyc = 0;
  int ev_count, m_count, first_m_cyc, last_m_cyc, fmt_pulses, seq_pulses, ev_stall, eacc_cyc, q0_cyc;
  int tlast_idx[$];
  logic [31:0] last_ev_num;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Header-level model: applied to each qword the DUT accepts.
  task automatic model_accept(input logic [63:0] d, input bit rs);
    fw_t f;
    if (pos == 0) begin
      if (d[31:0] != MAGIC) begin
        exp_fmt = 1;
        if (m_fmt_cnt < 65535) m_fmt_cnt++;
      end else begin
        if (!(first || rs) && d[63:32] != prev + 32'd1) begin
          exp_seq = 1;
          if (m_seq_cnt < 65535) m_seq_cnt++;
        end
        prev = d[63:32]; first = 0; hdr[0] = d; pos = 1; q0_cyc = cyc;
        f.d = d; f.l = 0; fwd_q.push_back(f);
      end
    end else begin
      hdr[pos] = d;
      f.d = d; f.l = (pos == 15); fwd_q.push_back(f);
      if (pos == 15) begin pend = 1; pend_hdr = hdr; pos = 0; end
      else pos++;
    end
  endtask

  // Driver + single compare process.
  always @(negedge memclk) begin
    bit s_acc, m_acc, e_acc, exp_rdy;
    fw_t f;
    cyc++;
    if (!memresetn) begin
      fwd_q.delete(); pos = 0; pend = 0; first = 1; exp_fmt = 0; exp_seq = 0;
      m_fmt_cnt = 0; m_seq_cnt = 0; since_rst = 0; acc_prev = 0;
      s_if.tvalid = 0; resync_i = 0;
      #1;
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_ev_valid", ev_valid, 0);
      chk("rst_err_format_o", err_format_o, 0);
      chk("rst_err_seq_o", err_seq_o, 0);
      chk("rst_err_format_cnt", err_format_cnt, 0);
      chk("rst_err_seq_cnt", err_seq_cnt, 0);
    end else begin
      since_rst++;
      if (!s_if.tvalid || acc_prev) begin
        s_if.tvalid = 0;
        if (src_q.size() != 0 && since_rst > 2 && (!rnd_gap || $urandom_range(3) != 0)) begin
          cur = src_q.pop_front();
          s_if.tvalid = 1; s_if.tdata = cur.d;
        end
      end
      resync_i = (s_if.tvalid && cur.r) || resync_req;
      resync_req = 0;
      m_if.tready = rnd_mready ? 1'($urandom_range(1)) : 1'b1;
      ev_ready = (ev_hold > 0) ? 1'b0 : (rnd_evready ? 1'($urandom_range(1)) : 1'b1);
      #1;
      s_acc = s_if.tvalid && s_if.tready;
      m_acc = m_if.tvalid && m_if.tready;
      e_acc = ev_valid && ev_ready;
      chk("err_format_o", err_format_o, exp_fmt);
      chk("err_seq_o", err_seq_o, exp_seq);
      chk("err_format_cnt", err_format_cnt, m_fmt_cnt);
      chk("err_seq_cnt", err_seq_cnt, m_seq_cnt);
      if (err_format_o) fmt_pulses++;
      if (err_seq_o) seq_pulses++;
      if (s_if.tvalid) begin
        if (pend) exp_rdy = 0;
        else if (pos == 0 && s_if.tdata[31:0] != MAGIC) exp_rdy = 1;
        else exp_rdy = (fwd_q.size() == 0) || m_if.tready;
        chk("s_tready", s_if.tready, exp_rdy);
      end
      chk("m_tvalid", m_if.tvalid, fwd_q.size() != 0);
      if (m_if.tvalid && fwd_q.size() != 0) begin
        chk("m_tdata", m_if.tdata, fwd_q[0].d);
        chk("m_tlast", m_if.tlast, fwd_q[0].l);
        if (m_acc) begin
          f = fwd_q.pop_front();
          if (f.l) tlast_idx.push_back(m_count);
          if (first_m_cyc < 0) first_m_cyc = cyc;
          last_m_cyc = cyc;
          m_count++;
        end
      end
      chk("ev_valid", ev_valid, pend);
      if (pend && ev_valid) begin
        chk("ev_number", ev_number, pend_hdr[0][63:32]);
        chk("ev_sec", ev_sec, pend_hdr[1][31:0]);
        chk("ev_time", ev_time, pend_hdr[1][63:32]);
        chk("ev_last_pps", ev_last_pps, pend_hdr[2][31:0]);
        chk("ev_llast_pps", ev_llast_pps, pend_hdr[2][63:32]);
        chk("ev_tio_mask", ev_tio_mask, pend_hdr[15][47:44]);
        chk("ev_runcfg", ev_runcfg, pend_hdr[15][43:32]);
        chk("ev_surf_words", ev_surf_words, pend_hdr[15][63:48]);
      end
      if (ev_valid && !ev_ready && ev_hold > 0) begin ev_hold--; ev_stall++; end
      if (e_acc) begin ev_count++; pend = 0; eacc_cyc = cyc; last_ev_num = ev_number; end
      exp_fmt = 0; exp_seq = 0;
      if (s_acc) model_accept(s_if.tdata, resync_i);
      else if (resync_i) first = 1;
      acc_prev = s_acc;
    end
  end

  task automatic push_hdr(input logic [31:0] num, input bit rs);
    src_t e;
    e.d = {num, MAGIC}; e.r = rs; src_q.push_back(e);
    for (int i = 1; i < 16; i++) begin
      e.d = {$urandom, $urandom}; e.r = 0; src_q.push_back(e);
    end
  endtask

  task automatic push_bad(input logic [31:0] lo);
    src_t e;
    e.d = {$urandom, lo}; e.r = 0; src_q.push_back(e);
  endtask

  task automatic start_test();
    ev_count = 0; m_count = 0; first_m_cyc = -1; last_m_cyc = 0;
    fmt_pulses = 0; seq_pulses = 0; ev_stall = 0; tlast_idx.delete();
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge memclk); #2;
      done = (src_q.size() == 0) && (!s_if.tvalid || acc_prev) && fwd_q.size() == 0 && !pend && pos == 0;
    end
    repeat (2) @(negedge memclk);
    #2;
    chk("idle_reached", done, 1);
  endtask

  task automatic do_reset();
    @(negedge memclk); #3 memresetn = 0;
    src_q.delete();
    repeat (3) @(negedge memclk);
    #3 memresetn = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nhdr;
    logic [31:0] num;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0;
    m_if.tready = 1; ev_ready = 1; resync_i = 0;
    #1 memresetn = 0;
    repeat (3) @(negedge memclk);
    #3 memresetn = 1;

    // 1: three back-to-back headers at full rate
    start_test();
    push_hdr(5, 0); push_hdr(6, 0); push_hdr(7, 0);
    wait_idle(400);
    chk("t1_fwd_count", m_count, 48);
    chk("t1_tlast_n", tlast_idx.size(), 3);
    if (tlast_idx.size() == 3) begin
      chk("t1_tlast0", tlast_idx[0], 15);
      chk("t1_tlast1", tlast_idx[1], 31);
      chk("t1_tlast2", tlast_idx[2], 47);
    end
    // 16 per header at 1/clk, one summary clock between headers
    chk("t1_span", last_m_cyc - first_m_cyc, 49);
    chk("t1_ev_count", ev_count, 3);
    chk("t1_errs", {err_format_cnt, err_seq_cnt}, 0);

    // 2: bad qword0 dropped
    do_reset(); start_test();
    push_bad({16'h4531, 16'd62}); push_hdr(9, 0);
    wait_idle(400);
    chk("t2_fmt_cnt", err_format_cnt, 1);
    chk("t2_fmt_pulses", fmt_pulses, 1);
    chk("t2_ev_count", ev_count, 1);
    chk("t2_ev_num", last_ev_num, 9);
    chk("t2_fwd_count", m_count, 16);

    // 3: discontinuity 10 -> 12
    do_reset(); start_test();
    push_hdr(10, 0); push_hdr(12, 0);
    wait_idle(400);
    chk("t3_seq_cnt", err_seq_cnt, 1);
    chk("t3_seq_pulses", seq_pulses, 1);
    chk("t3_fwd_count", m_count, 32);
    chk("t3_ev_count", ev_count, 2);

    // 4: wrap, standalone resync, coincident resync, then a real gap
    do_reset(); start_test();
    push_hdr(32'hFFFF_FFFF, 0); push_hdr(0, 0);
    wait_idle(400);
    chk("t4_wrap_seq", err_seq_cnt, 0);
    resync_req = 1;
    repeat (2) @(negedge memclk);
    push_hdr(100, 0);
    wait_idle(400);
    chk("t4_resync_seq", err_seq_cnt, 0);
    push_hdr(555, 1);
    wait_idle(400);
    chk("t4_coinc_seq", err_seq_cnt, 0);
    push_hdr(557, 0);
    wait_idle(400);
    chk("t4_gap_seq", err_seq_cnt, 1);
    chk("t4_ev_count", ev_count, 5);

    // 5: summary held 20 clocks with the next header queued
    do_reset(); start_test();
    ev_hold = 20;
    push_hdr(20, 0); push_hdr(21, 0);
    wait_idle(600);
    chk("t5_stall", ev_stall, 20);
    chk("t5_ev_count", ev_count, 2);
    chk("t5_seq_cnt", err_seq_cnt, 0);
    chk("t5_ev_num", last_ev_num, 21);

    // 6: async reset in the middle of a header
    do_reset(); start_test();
    push_bad($urandom); push_hdr(30, 0); push_hdr(40, 0);
    wait_idle(400);
    chk("t6_pre_fmt", err_format_cnt, 1);
    chk("t6_pre_seq", err_seq_cnt, 1);
    push_hdr(50, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge memclk); #2;
      if (pos == 7) break;
    end
    chk("t6_reach_q7", pos, 7);
    #1 memresetn = 0;
    src_q.delete();
    repeat (3) @(negedge memclk);
    #3 memresetn = 1;
    start_test();
    push_hdr(12345, 0);
    wait_idle(400);
    chk("t6_post_seq", err_seq_cnt, 0);
    chk("t6_post_fmt", err_format_cnt, 0);
    chk("t6_post_ev", ev_count, 1);
    chk("t6_post_num", last_ev_num, 12345);

    // Randomized: throttling, gaps, bad words, jumps, resyncs
    do_reset(); start_test();
    rnd_mready = 1; rnd_evready = 1; rnd_gap = 1;
    nhdr = 0; num = $urandom;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(9) == 0) push_bad($urandom_range(1) ? {16'h4531, 16'($urandom_range(62))} : $urandom);
      if ($urandom_range(4) == 0) num = $urandom; else num = num + 1;
      if ($urandom_range(9) == 0) resync_req = 1;
      push_hdr(num, $urandom_range(9) == 0);
      nhdr++;
      if ($urandom_range(3) == 0) wait_idle(2000);
    end
    wait_idle(5000);
    chk("rnd_fwd_count", m_count, nhdr * 16);
    chk("rnd_ev_count", ev_count, nhdr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
